// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: forwarding-select encodings and the
// fixed field widths used by the EX/MEM slice.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    localparam int PC_W      = 64;
    localparam int DATA_W    = 32;

    // ALU operand source selects
    localparam logic [1:0] FWD_NONE  = 2'b00;  // register file
    localparam logic [1:0] FWD_MEMWB = 2'b01;  // MEM/WB result
    localparam logic [1:0] FWD_EXMEM = 2'b10;  // EX/MEM result (newest)

    // A destination forwards only if it is written and is not x0
    function automatic logic dest_matches(
        input logic                 regwrite,
        input logic [REG_IDX_W-1:0] rd,
        input logic [REG_IDX_W-1:0] rs
    );
        return regwrite && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/ex_mem_fwd_hazard_fwd_select.sv
// Per-operand forwarding comparator: picks EX/MEM, MEM/WB or the register
// file for one ALU source register.
module fwd_select
    import pipe_ctrl_pkg::*;
(
    input  logic                 ex_mem_regwrite,
    input  logic [REG_IDX_W-1:0] ex_mem_rd,
    input  logic                 mem_wb_regwrite,
    input  logic [REG_IDX_W-1:0] mem_wb_rd,
    input  logic [REG_IDX_W-1:0] rs,
    output logic [1:0]           fwd_sel
);

    // EX/MEM is checked first because it holds the newer value
    always_comb begin
        fwd_sel = FWD_NONE;
        if (dest_matches(ex_mem_regwrite, ex_mem_rd, rs)) begin
            fwd_sel = FWD_EXMEM;
        end else if (dest_matches(mem_wb_regwrite, mem_wb_rd, rs)) begin
            fwd_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/ex_mem_fwd_hazard.sv
// EX/MEM pipeline register with EX-stage operand forwarding and load-use
// stall detection.
// Optional build macro EX_MEM_FLUSH_EN adds a 'flush' input that turns the
// captured control bits into a bubble while data fields load normally.
module ex_mem_fwd_hazard
    import pipe_ctrl_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
`ifdef EX_MEM_FLUSH_EN
    input  logic                 flush,
`endif
    input  logic [PC_W-1:0]      pc_in,
    input  logic                 zero_in,
    input  logic [DATA_W-1:0]    alu_result_in,
    input  logic [DATA_W-1:0]    read_data2_in,
    input  logic [REG_IDX_W-1:0] write_reg_in,
    input  logic                 branch_in,
    input  logic                 memwrite_in,
    input  logic                 memread_in,
    input  logic                 memtoreg_in,
    input  logic                 regwrite_in,
    output logic [PC_W-1:0]      pc_out,
    output logic                 zero_out,
    output logic [DATA_W-1:0]    alu_result_out,
    output logic [DATA_W-1:0]    read_data2_out,
    output logic [REG_IDX_W-1:0] write_reg_out,
    output logic                 branch_out,
    output logic                 memwrite_out,
    output logic                 memread_out,
    output logic                 memtoreg_out,
    output logic                 regwrite_out,
    input  logic [REG_IDX_W-1:0] id_ex_rs1,
    input  logic [REG_IDX_W-1:0] id_ex_rs2,
    input  logic [REG_IDX_W-1:0] mem_wb_rd,
    input  logic                 mem_wb_regwrite,
    output logic [1:0]           forward_a,
    output logic [1:0]           forward_b,
    input  logic                 id_ex_memread,
    input  logic [REG_IDX_W-1:0] id_ex_rd,
    input  logic [REG_IDX_W-1:0] if_id_rs1,
    input  logic [REG_IDX_W-1:0] if_id_rs2,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 stall
);

    logic [PC_W-1:0]      pc_reg;
    logic                 zero_reg;
    logic [DATA_W-1:0]    alu_result_reg;
    logic [DATA_W-1:0]    read_data2_reg;
    logic [REG_IDX_W-1:0] write_reg_reg;
    // {branch, memwrite, memread, memtoreg, regwrite}
    logic [4:0]           ctrl_reg;
    logic [4:0]           ctrl_next;

    // Control bits to capture; a flush squashes them into a bubble
    always_comb begin
        ctrl_next = {branch_in, memwrite_in, memread_in, memtoreg_in, regwrite_in};
`ifdef EX_MEM_FLUSH_EN
        if (flush) begin
            ctrl_next = '0;
        end
`endif
    end

    // EX/MEM register: unconditional capture, reset loads an all-zero bubble
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg         <= '0;
            zero_reg       <= 1'b0;
            alu_result_reg <= '0;
            read_data2_reg <= '0;
            write_reg_reg  <= '0;
            ctrl_reg       <= '0;
        end else begin
            pc_reg         <= pc_in;
            zero_reg       <= zero_in;
            alu_result_reg <= alu_result_in;
            read_data2_reg <= read_data2_in;
            write_reg_reg  <= write_reg_in;
            ctrl_reg       <= ctrl_next;
        end
    end

    assign pc_out         = pc_reg;
    assign zero_out       = zero_reg;
    assign alu_result_out = alu_result_reg;
    assign read_data2_out = read_data2_reg;
    assign write_reg_out  = write_reg_reg;
    assign branch_out     = ctrl_reg[4];
    assign memwrite_out   = ctrl_reg[3];
    assign memread_out    = ctrl_reg[2];
    assign memtoreg_out   = ctrl_reg[1];
    assign regwrite_out   = ctrl_reg[0];

    // One comparator per ALU operand; index 0 is operand A, 1 is operand B
    logic [REG_IDX_W-1:0] src_rs  [2];
    logic [1:0]           fwd_sel [2];

    assign src_rs[0] = id_ex_rs1;
    assign src_rs[1] = id_ex_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_select u_fwd_select (
                .ex_mem_regwrite (ctrl_reg[0]),
                .ex_mem_rd       (write_reg_reg),
                .mem_wb_regwrite (mem_wb_regwrite),
                .mem_wb_rd       (mem_wb_rd),
                .rs              (src_rs[gi]),
                .fwd_sel         (fwd_sel[gi])
            );
        end
    endgenerate

    assign forward_a = fwd_sel[0];
    assign forward_b = fwd_sel[1];

    // Load-use hazard: the load in EX writes a register the ID instruction reads
    always_comb begin
        stall = id_ex_memread && (id_ex_rd != '0) &&
                ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
    end

    assign pc_write    = ~stall;
    assign if_id_write = ~stall;

endmodule

// File: tb/tb_ex_mem_fwd_hazard.sv
// Scoreboard bench for ex_mem_fwd_hazard: the stimulus process drives one
// directed vector per cycle and queues its hand-computed expectation; the
// monitor samples on the falling edge and compares against the queue head.
module tb_ex_mem_fwd_hazard;

    logic        clock;
    logic        reset;
    logic        flush;
    logic [63:0] pc_in;
    logic        zero_in;
    logic [31:0] alu_result_in;
    logic [31:0] read_data2_in;
    logic [4:0]  write_reg_in;
    logic        branch_in, memwrite_in, memread_in, memtoreg_in, regwrite_in;
    logic [63:0] pc_out;
    logic        zero_out;
    logic [31:0] alu_result_out;
    logic [31:0] read_data2_out;
    logic [4:0]  write_reg_out;
    logic        branch_out, memwrite_out, memread_out, memtoreg_out, regwrite_out;
    logic [4:0]  id_ex_rs1, id_ex_rs2, mem_wb_rd;
    logic        mem_wb_regwrite;
    logic [1:0]  forward_a, forward_b;
    logic        id_ex_memread;
    logic [4:0]  id_ex_rd, if_id_rs1, if_id_rs2;
    logic        pc_write, if_id_write, stall;

    ex_mem_fwd_hazard dut (
        .clock           (clock),
        .reset           (reset),
`ifdef EX_MEM_FLUSH_EN
        .flush           (flush),
`endif
        .pc_in           (pc_in),
        .zero_in         (zero_in),
        .alu_result_in   (alu_result_in),
        .read_data2_in   (read_data2_in),
        .write_reg_in    (write_reg_in),
        .branch_in       (branch_in),
        .memwrite_in     (memwrite_in),
        .memread_in      (memread_in),
        .memtoreg_in     (memtoreg_in),
        .regwrite_in     (regwrite_in),
        .pc_out          (pc_out),
        .zero_out        (zero_out),
        .alu_result_out  (alu_result_out),
        .read_data2_out  (read_data2_out),
        .write_reg_out   (write_reg_out),
        .branch_out      (branch_out),
        .memwrite_out    (memwrite_out),
        .memread_out     (memread_out),
        .memtoreg_out    (memtoreg_out),
        .regwrite_out    (regwrite_out),
        .id_ex_rs1       (id_ex_rs1),
        .id_ex_rs2       (id_ex_rs2),
        .mem_wb_rd       (mem_wb_rd),
        .mem_wb_regwrite (mem_wb_regwrite),
        .forward_a       (forward_a),
        .forward_b       (forward_b),
        .id_ex_memread   (id_ex_memread),
        .id_ex_rd        (id_ex_rd),
        .if_id_rs1       (if_id_rs1),
        .if_id_rs2       (if_id_rs2),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .stall           (stall)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        string       name;
        logic [63:0] pc;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  wr;
        logic [4:0]  ctrl;   // {branch, memwrite, memread, memtoreg, regwrite}
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        stall;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string name, input string field,
                       input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%0h required=%0h", name, field, act, req);
        end
    endtask

    // Monitor: one sample per falling edge whenever an expectation is pending
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.name, "pc_out",         pc_out,         e.pc);
            cmp(e.name, "zero_out",       zero_out,       e.zero);
            cmp(e.name, "alu_result_out", alu_result_out, e.alu);
            cmp(e.name, "read_data2_out", read_data2_out, e.rd2);
            cmp(e.name, "write_reg_out",  write_reg_out,  e.wr);
            cmp(e.name, "ctrl_out",
                {branch_out, memwrite_out, memread_out, memtoreg_out, regwrite_out}, e.ctrl);
            cmp(e.name, "forward_a",      forward_a,      e.fa);
            cmp(e.name, "forward_b",      forward_b,      e.fb);
            cmp(e.name, "stall",          stall,          e.stall);
            cmp(e.name, "pc_write",       pc_write,       !e.stall);
            cmp(e.name, "if_id_write",    if_id_write,    !e.stall);
            $display("txn %-10s pc=%0h alu=%0h wr=%0d ctrl=%b fa=%b fb=%b stall=%b",
                     e.name, pc_out, alu_result_out, write_reg_out,
                     {branch_out, memwrite_out, memread_out, memtoreg_out, regwrite_out},
                     forward_a, forward_b, stall);
        end
    end

    task automatic set_ex(input logic [63:0] pc, input logic z, input logic [31:0] alu,
                          input logic [31:0] rd2, input logic [4:0] wr, input logic [4:0] ctrl);
        pc_in = pc; zero_in = z; alu_result_in = alu; read_data2_in = rd2; write_reg_in = wr;
        {branch_in, memwrite_in, memread_in, memtoreg_in, regwrite_in} = ctrl;
    endtask

    task automatic set_fwd(input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] mwrd, input logic mwrw);
        id_ex_rs1 = rs1; id_ex_rs2 = rs2; mem_wb_rd = mwrd; mem_wb_regwrite = mwrw;
    endtask

    task automatic set_haz(input logic mr, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2);
        id_ex_memread = mr; id_ex_rd = rd; if_id_rs1 = rs1; if_id_rs2 = rs2;
    endtask

    task automatic expect_out(input string name, input logic [63:0] pc, input logic z,
                              input logic [31:0] alu, input logic [31:0] rd2,
                              input logic [4:0] wr, input logic [4:0] ctrl,
                              input logic [1:0] fa, input logic [1:0] fb, input logic st);
        exp_t e;
        e.name = name; e.pc = pc; e.zero = z; e.alu = alu; e.rd2 = rd2; e.wr = wr;
        e.ctrl = ctrl; e.fa = fa; e.fb = fb; e.stall = st;
        exp_q.push_back(e);
    endtask

    // Inputs change 2 time units after the rising edge
    task automatic next_cycle;
        @(posedge clock);
        #2;
    endtask

    logic [4:0] flushed_ctrl;

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        set_ex(64'h0, 1'b0, 32'h0, 32'h0, 5'd0, 5'b00000);
        set_fwd(5'd0, 5'd0, 5'd0, 1'b0);
        set_haz(1'b0, 5'd0, 5'd0, 5'd0);
        repeat (3) @(posedge clock);

        // Non-zero inputs; register still holds the reset bubble
        next_cycle();
        reset = 1'b0;
        set_ex(64'hDEAD_BEEF_0000_1234, 1'b1, 32'hFFFF_0001, 32'h1234_5678, 5'd7, 5'b11111);
        set_fwd(5'd3, 5'd3, 5'd3, 1'b1);
        set_haz(1'b1, 5'd7, 5'd7, 5'd0);
        expect_out("rst_state", 64'h0, 1'b0, 32'h0, 32'h0, 5'd0, 5'b00000, 2'b01, 2'b01, 1'b1);

        // Mid-stream reset asserted; values captured last edge are visible
        next_cycle();
        reset = 1'b1;
        expect_out("pre_rst", 64'hDEAD_BEEF_0000_1234, 1'b1, 32'hFFFF_0001, 32'h1234_5678,
                   5'd7, 5'b11111, 2'b01, 2'b01, 1'b1);

        // Reset edge cleared everything despite non-zero inputs; stall unaffected
        next_cycle();
        reset = 1'b0;
        expect_out("rst_clear", 64'h0, 1'b0, 32'h0, 32'h0, 5'd0, 5'b00000, 2'b01, 2'b01, 1'b1);

        // Capture vector driven
        next_cycle();
        set_ex(64'h40, 1'b0, 32'h1F, 32'h0, 5'd5, 5'b00001);
        set_fwd(5'd0, 5'd0, 5'd0, 1'b0);
        set_haz(1'b0, 5'd0, 5'd0, 5'd0);
        expect_out("reload", 64'hDEAD_BEEF_0000_1234, 1'b1, 32'hFFFF_0001, 32'h1234_5678,
                   5'd7, 5'b11111, 2'b00, 2'b00, 1'b0);

        // Capture visible after one edge; x5 forwards to A from EX/MEM
        next_cycle();
        set_ex(64'h44, 1'b0, 32'h2A, 32'h99, 5'd10, 5'b00001);
        set_fwd(5'd5, 5'd0, 5'd0, 1'b0);
        expect_out("capture", 64'h40, 1'b0, 32'h1F, 32'h0, 5'd5, 5'b00001, 2'b10, 2'b00, 1'b0);

        // Both stages hold x10: EX/MEM wins for A, B (x11) unmatched
        next_cycle();
        set_ex(64'h48, 1'b0, 32'h0, 32'h0, 5'd10, 5'b00000);
        set_fwd(5'd10, 5'd11, 5'd10, 1'b1);
        expect_out("priority", 64'h44, 1'b0, 32'h2A, 32'h99, 5'd10, 5'b00001, 2'b10, 2'b00, 1'b0);

        // regwrite_out cleared: A falls back to MEM/WB
        next_cycle();
        expect_out("memwb_fb", 64'h48, 1'b0, 32'h0, 32'h0, 5'd10, 5'b00000, 2'b01, 2'b00, 1'b0);

        // x0 destination everywhere
        next_cycle();
        set_ex(64'h0, 1'b0, 32'h0, 32'h0, 5'd0, 5'b00001);
        set_fwd(5'd0, 5'd0, 5'd0, 1'b1);
        expect_out("x0_memwb", 64'h48, 1'b0, 32'h0, 32'h0, 5'd10, 5'b00000, 2'b00, 2'b00, 1'b0);

        next_cycle();
        expect_out("x0_exmem", 64'h0, 1'b0, 32'h0, 32'h0, 5'd0, 5'b00001, 2'b00, 2'b00, 1'b0);

        // Operand B from MEM/WB
        next_cycle();
        set_ex(64'h50, 1'b0, 32'h0, 32'h0, 5'd6, 5'b00001);
        set_fwd(5'd9, 5'd4, 5'd4, 1'b1);
        expect_out("b_memwb", 64'h0, 1'b0, 32'h0, 32'h0, 5'd0, 5'b00001, 2'b00, 2'b01, 1'b0);

        // Both operands from EX/MEM over MEM/WB; load-use on rs2
        next_cycle();
        set_fwd(5'd6, 5'd6, 5'd6, 1'b1);
        set_haz(1'b1, 5'd12, 5'd3, 5'd12);
        expect_out("ab_exmem", 64'h50, 1'b0, 32'h0, 32'h0, 5'd6, 5'b00001, 2'b10, 2'b10, 1'b1);

        // Not a load: no stall
        next_cycle();
        set_haz(1'b0, 5'd12, 5'd3, 5'd12);
        expect_out("no_load", 64'h50, 1'b0, 32'h0, 32'h0, 5'd6, 5'b00001, 2'b10, 2'b10, 1'b0);

        // Load into x0 never stalls
        next_cycle();
        set_ex(64'h60, 1'b1, 32'h8, 32'h77, 5'd9, 5'b01001);
        set_fwd(5'd0, 5'd0, 5'd0, 1'b0);
        set_haz(1'b1, 5'd0, 5'd0, 5'd12);
        expect_out("ld_x0", 64'h50, 1'b0, 32'h0, 32'h0, 5'd6, 5'b00001, 2'b00, 2'b00, 1'b0);

        // Load-use on rs1; flush asserted for the coming edge
        next_cycle();
        flush = 1'b1;
        set_haz(1'b1, 5'd12, 5'd12, 5'd0);
        expect_out("ld_rs1", 64'h60, 1'b1, 32'h8, 32'h77, 5'd9, 5'b01001, 2'b00, 2'b00, 1'b1);

        // Flushed capture: controls squashed, data kept (full capture without flush)
`ifdef EX_MEM_FLUSH_EN
        flushed_ctrl = 5'b00000;
`else
        flushed_ctrl = 5'b01001;
`endif
        next_cycle();
        flush = 1'b0;
        set_haz(1'b0, 5'd0, 5'd0, 5'd0);
        expect_out("flush", 64'h60, 1'b1, 32'h8, 32'h77, 5'd9, flushed_ctrl, 2'b00, 2'b00, 1'b0);

        // Reset and flush together: reset clears every field
        next_cycle();
        reset = 1'b1;
        flush = 1'b1;
        expect_out("pre_rstfl", 64'h60, 1'b1, 32'h8, 32'h77, 5'd9, 5'b01001, 2'b00, 2'b00, 1'b0);

        next_cycle();
        reset = 1'b0;
        flush = 1'b0;
        expect_out("rst_flush", 64'h0, 1'b0, 32'h0, 32'h0, 5'd0, 5'b00000, 2'b00, 2'b00, 1'b0);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
